mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares one single-port unified instruction/data memory between the pipeline's instruction-fetch (IF) requester and data-memory (MEM) requester.
- Sequences each access through a fixed-latency memory and returns read data to the winning requester.
- Produces per-requester stall signals for the hazard/stall logic in `Top`.
- Sits between the IF/MEM pipeline stages and the memory model; no other block drives the memory port.

## Interface
Parameters:
- MEM_LATENCY, 2, cycles from MemEn high to MemRdata valid; legal range 1..15.
- ADDR_W, 32, address width.

Ports:
- Clk  in  1  single clock, rising-edge.
- Reset  in  1  synchronous, active-high; sampled on rising Clk.
- IfReq  in  1  fetch request; level, held until IfDone.
- IfAddr  in  ADDR_W  fetch address; stable while IfReq high.
- IfRdata  out  32  fetched word; valid in IfDone cycle, held until next fetch capture.
- IfDone  out  1  one-cycle completion pulse for fetch.
- IfStall  out  1  IfReq & ~IfDone.
- DmReq  in  1  data request; level, held until DmDone.
- DmWe  in  1  1 = write, 0 = read; stable while DmReq high.
- DmAddr  in  ADDR_W  data address; stable while DmReq high.
- DmWdata  in  32  write data; stable while DmReq high.
- DmRdata  out  32  load data; valid in DmDone cycle, held until next data-read capture.
- DmDone  out  1  one-cycle completion pulse for data access.
- DmStall  out  1  DmReq & ~DmDone.
- MemEn  out  1  memory access strobe, exactly one cycle per access.
- MemWe  out  1  write strobe, qualified by MemEn.
- MemAddr  out  ADDR_W  registered address, held for the whole access.
- MemWdata  out  32  registered write data.
- MemRdata  in  32  memory read data; valid exactly MEM_LATENCY cycles after MemEn.
- Busy  out  1  high in every state except IDLE.
- WaitCount  out  16  saturating count of cycles in which a request was high but not granted.

## Operation
States:
- IDLE
- ISSUE (MemEn=1)
- WAIT (latency counter running)
- DONE (Done pulse)

Transitions:
- IDLE -> ISSUE when IfReq | DmReq.
  - Owner, address, We and Wdata are latched at that edge.
- ISSUE -> WAIT, counter loaded with MEM_LATENCY-1.
- WAIT decrements the counter each cycle; WAIT -> DONE when counter==0.
  - MemRdata is captured into IfRdata or DmRdata on the WAIT->DONE edge (reads only).
- DONE -> IDLE unconditionally.

Arbitration (IDLE only):
- Only DmReq -> data. Only IfReq -> fetch.
- Both requests high -> data wins unless LastGrantData=1, in which case fetch wins.
- LastGrantData is updated on every grant and cleared by reset, so the first conflict after reset goes to data.

Other rules:
- Writes use the same sequence and latency as reads; DmRdata is unchanged by a write.
- A request high in the cycle after its Done is treated as a new request.
- Requester inputs are ignored outside IDLE; changing them mid-access does not affect the access in flight.
- WaitCount increments in any cycle where (IfReq & ~(granted-or-owner fetch)) | (DmReq & ~(granted-or-owner data)).
  - Simpler equivalent: increments when some request is high and that requester is not the current or just-granted owner.
  - Saturates at 0xFFFF.

Reset (any state, including mid-access):
- State -> IDLE, counter -> 0, LastGrantData -> 0, WaitCount -> 0.
- MemEn, MemWe, IfDone, DmDone -> 0; MemAddr, MemWdata, IfRdata, DmRdata -> 0.
- An in-flight access is abandoned with no Done pulse. Busy = 0.

## Timing
- Request high in IDLE at cycle t:
  - MemEn at t+1.
  - MemRdata sampled at end of cycle t+1+MEM_LATENCY.
  - Done at t+2+MEM_LATENCY.
- Request-to-Done latency = MEM_LATENCY+2 cycles (4 at default).
- Back-to-back throughput: one access per MEM_LATENCY+3 cycles (IDLE cycle included).
- All outputs registered except IfStall and DmStall (combinational from Req and Done).
- MemEn is never high in two consecutive cycles.
- Exactly one Done pulse per granted access; IfDone and DmDone are never high together.

## Test plan
- Single fetch, MEM_LATENCY=2: IfReq=1, IfAddr=0x40, memory returns 0x8C220004.
  - MemEn at t+1 with MemAddr=0x40; IfDone at t+4 with IfRdata=0x8C220004.
  - IfStall high t..t+3, low at t+4.
- Store then load: DmWe=1, DmAddr=0x100, DmWdata=0xDEADBEEF.
  - MemWe=1 with MemEn and MemWdata=0xDEADBEEF; DmDone at t+4; DmRdata unchanged.
  - A following read of 0x100 returns 0xDEADBEEF on DmDone.
- Conflict after reset: IfReq and DmReq both high at t.
  - Data granted first (DmDone t+4); fetch granted in the following IDLE (IfDone t+9).
  - WaitCount=5 at fetch grant.
- Alternation under continuous conflict: both requests held, re-raised after each Done, for 4 accesses.
  - Grant order is data, fetch, data, fetch.
- Reset mid-access: Reset asserted during WAIT.
  - Next cycle: Busy=0, MemEn=0, no Done pulse, WaitCount=0.
  - A new fetch issued after reset completes normally in 4 cycles.
- MEM_LATENCY=1 and MEM_LATENCY=15 instances:
  - Done at t+3 and t+17 respectively.
  - MemEn is a single-cycle pulse in both.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: shares one fixed-latency single-port memory between the IF and MEM requesters.
// Rev 1.0 - initial release.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IfReq,
  input  logic [ADDR_W-1:0] IfAddr,
  output logic [31:0]       IfRdata,
  output logic              IfDone,
  output logic              IfStall,
  input  logic              DmReq,
  input  logic              DmWe,
  input  logic [ADDR_W-1:0] DmAddr,
  input  logic [31:0]       DmWdata,
  output logic [31:0]       DmRdata,
  output logic              DmDone,
  output logic              DmStall,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWdata,
  input  logic [31:0]       MemRdata,
  output logic              Busy,
  output logic [15:0]       WaitCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  lat_cnt;
  logic        owner_data;
  logic        access_we;
  logic        last_grant_data;
  logic        grant_data;
  logic        grant_fetch;
  logic        fetch_active;
  logic        data_active;
  logic        wait_inc;

  // Data wins a conflict unless it won the previous grant, giving strict alternation.
  always_comb begin
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    state_nxt   = state;
    if (state == IDLE) begin
      grant_data  = DmReq & (~IfReq | ~last_grant_data);
      grant_fetch = IfReq & ~grant_data;
    end
    case (state)
      IDLE:    if (IfReq | DmReq) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    fetch_active = (state == IDLE) ? grant_fetch : ~owner_data;
    data_active  = (state == IDLE) ? grant_data  : owner_data;
    wait_inc     = (IfReq & ~fetch_active) | (DmReq & ~data_active);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= IDLE;
      lat_cnt         <= 4'd0;
      owner_data      <= 1'b0;
      access_we       <= 1'b0;
      last_grant_data <= 1'b0;
      WaitCount       <= 16'd0;
      MemEn           <= 1'b0;
      MemWe           <= 1'b0;
      MemAddr         <= '0;
      MemWdata        <= 32'd0;
      IfRdata         <= 32'd0;
      DmRdata         <= 32'd0;
      IfDone          <= 1'b0;
      DmDone          <= 1'b0;
      Busy            <= 1'b0;
    end else begin
      state  <= state_nxt;
      Busy   <= (state_nxt != IDLE);
      MemEn  <= 1'b0;
      MemWe  <= 1'b0;
      IfDone <= 1'b0;
      DmDone <= 1'b0;
      if (wait_inc && (WaitCount != 16'hFFFF)) begin
        WaitCount <= WaitCount + 16'd1;
      end
      case (state)
        IDLE: begin
          if (grant_data | grant_fetch) begin
            owner_data      <= grant_data;
            last_grant_data <= grant_data;
            access_we       <= grant_data & DmWe;
            MemEn           <= 1'b1;
            MemWe           <= grant_data & DmWe;
            MemAddr         <= grant_data ? DmAddr : IfAddr;
            if (grant_data) MemWdata <= DmWdata;
          end
        end
        ISSUE: lat_cnt <= LAT_LOAD;
        WAIT: begin
          if (lat_cnt == 4'd0) begin
            IfDone <= ~owner_data;
            DmDone <= owner_data;
            // Read data lands exactly as the counter expires; writes leave DmRdata alone.
            if (~owner_data) begin
              IfRdata <= MemRdata;
            end else if (~access_we) begin
              DmRdata <= MemRdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign IfStall = IfReq & ~IfDone;
  assign DmStall = DmReq & ~DmDone;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: scoreboard bench over three arbiter instances (latency 2, 1 and 15).
module tb_mem_port_arbiter;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
    int          cyc;
  } done_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } iss_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic        if_req     [3];
  logic [31:0] if_addr    [3];
  logic [31:0] if_rdata   [3];
  logic        if_done    [3];
  logic        if_stall   [3];
  logic        dm_req     [3];
  logic        dm_we      [3];
  logic [31:0] dm_addr    [3];
  logic [31:0] dm_wdata   [3];
  logic [31:0] dm_rdata   [3];
  logic        dm_done    [3];
  logic        dm_stall   [3];
  logic        mem_en     [3];
  logic        mem_we     [3];
  logic [31:0] mem_addr   [3];
  logic [31:0] mem_wdata  [3];
  logic [31:0] mem_rdata  [3];
  logic        busy       [3];
  logic [15:0] wait_count [3];

  done_t done_q [3][$];
  iss_t  iss_q  [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic exp_done(input int inst, input logic is_data, input logic [31:0] rdata, input int c);
    done_t e;
    e.is_data = is_data;
    e.rdata   = rdata;
    e.cyc     = c;
    done_q[inst].push_back(e);
  endtask

  task automatic exp_iss(input int inst, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int c);
    iss_t s;
    s.we    = we;
    s.addr  = addr;
    s.wdata = wdata;
    s.cyc   = c;
    iss_q[inst].push_back(s);
  endtask

  // Raise a request, hold it through n Done pulses, checking the stall output each cycle.
  task automatic hold_req(input int inst, input logic is_data, input int n);
    int   seen;
    int   cnt;
    logic d;
    logic s;
    seen = 0;
    cnt  = 0;
    if (is_data) dm_req[inst] = 1'b1;
    else         if_req[inst] = 1'b1;
    while (seen < n && cnt < 60) begin
      @(negedge clk);
      cnt++;
      d = is_data ? dm_done[inst]  : if_done[inst];
      s = is_data ? dm_stall[inst] : if_stall[inst];
      check($sformatf("u%0d_%s_stall", inst, is_data ? "dm" : "if"), 32'(s), 32'(!d));
      if (d) seen++;
    end
    if (seen < n) check($sformatf("u%0d_done_timeout", inst), 32'(seen), 32'(n));
    @(posedge clk);
    #1;
    if (is_data) dm_req[inst] = 1'b0;
    else         if_req[inst] = 1'b0;
  endtask

  task automatic start(output int t);
    @(posedge clk);
    #1;
    t = cyc;
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 15);

    mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32)) u_dut (
      .Clk(clk), .Reset(rst),
      .IfReq(if_req[gi]), .IfAddr(if_addr[gi]), .IfRdata(if_rdata[gi]),
      .IfDone(if_done[gi]), .IfStall(if_stall[gi]),
      .DmReq(dm_req[gi]), .DmWe(dm_we[gi]), .DmAddr(dm_addr[gi]), .DmWdata(dm_wdata[gi]),
      .DmRdata(dm_rdata[gi]), .DmDone(dm_done[gi]), .DmStall(dm_stall[gi]),
      .MemEn(mem_en[gi]), .MemWe(mem_we[gi]), .MemAddr(mem_addr[gi]),
      .MemWdata(mem_wdata[gi]), .MemRdata(mem_rdata[gi]),
      .Busy(busy[gi]), .WaitCount(wait_count[gi])
    );

    // Memory model: read data is valid only in the cycle exactly LAT cycles after MemEn.
    logic [31:0]  mem [256];
    logic [255:0] wr_v;
    logic [31:0]  rd_data;
    int           k;

    always @(posedge clk) begin
      if (rst && cyc < 4) begin
        wr_v    <= '0;
        k       <= 0;
        rd_data <= 32'd0;
      end else begin
        if (k > 0) k <= k - 1;
        if (mem_en[gi] === 1'b1) begin
          if (mem_we[gi]) begin
            mem[mem_addr[gi][9:2]]  <= mem_wdata[gi];
            wr_v[mem_addr[gi][9:2]] <= 1'b1;
          end else begin
            rd_data <= wr_v[mem_addr[gi][9:2]] ? mem[mem_addr[gi][9:2]] : dflt(mem_addr[gi]);
            k       <= LAT;
          end
        end
      end
    end

    assign mem_rdata[gi] = (k == 1) ? rd_data : 32'hBAD0_BAD0;

    initial begin
      done_t e;
      iss_t  s;
      logic  prev_en;
      prev_en = 1'b0;
      forever begin
        @(negedge clk);
        if (rst) begin
          prev_en = 1'b0;
        end else begin
          if (if_done[gi] || dm_done[gi]) begin
            check($sformatf("u%0d_done_exclusive", gi), 32'(if_done[gi] & dm_done[gi]), 32'd0);
            if (done_q[gi].size() == 0) begin
              check($sformatf("u%0d_unexpected_done", gi), 32'd1, 32'd0);
            end else begin
              e = done_q[gi].pop_front();
              check($sformatf("u%0d_done_side", gi), 32'(dm_done[gi]), 32'(e.is_data));
              check($sformatf("u%0d_done_cycle", gi), 32'(cyc), 32'(e.cyc));
              check($sformatf("u%0d_rdata", gi), e.is_data ? dm_rdata[gi] : if_rdata[gi], e.rdata);
            end
          end
          if (mem_en[gi]) begin
            check($sformatf("u%0d_memen_single", gi), 32'(prev_en), 32'd0);
            if (iss_q[gi].size() == 0) begin
              check($sformatf("u%0d_unexpected_memen", gi), 32'd1, 32'd0);
            end else begin
              s = iss_q[gi].pop_front();
              check($sformatf("u%0d_issue_cycle", gi), 32'(cyc), 32'(s.cyc));
              check($sformatf("u%0d_mem_addr", gi), mem_addr[gi], s.addr);
              check($sformatf("u%0d_mem_we", gi), 32'(mem_we[gi]), 32'(s.we));
              if (s.we) check($sformatf("u%0d_mem_wdata", gi), mem_wdata[gi], s.wdata);
            end
          end
          prev_en = mem_en[gi];
        end
      end
    end
  end

  initial begin
    int t;
    for (int i = 0; i < 3; i++) begin
      if_req[i]   = 1'b0;
      if_addr[i]  = 32'd0;
      dm_req[i]   = 1'b0;
      dm_we[i]    = 1'b0;
      dm_addr[i]  = 32'd0;
      dm_wdata[i] = 32'd0;
    end
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d_rst_busy", i), 32'(busy[i]), 32'd0);
      check($sformatf("u%0d_rst_memen", i), 32'(mem_en[i]), 32'd0);
      check($sformatf("u%0d_rst_done", i), 32'(if_done[i] | dm_done[i]), 32'd0);
      check($sformatf("u%0d_rst_waitcount", i), 32'(wait_count[i]), 32'd0);
      check($sformatf("u%0d_rst_rdata", i), if_rdata[i] | dm_rdata[i] | mem_addr[i], 32'd0);
    end
    rst = 1'b0;

    // First conflict after reset: data first, fetch in the next IDLE.
    start(t);
    if_addr[0] = 32'h44;
    dm_addr[0] = 32'h80;
    dm_we[0]   = 1'b0;
    exp_iss(0, 1'b0, 32'h80, 32'd0, t + 1);
    exp_iss(0, 1'b0, 32'h44, 32'd0, t + 6);
    exp_done(0, 1'b1, 32'h0080_FF7F, t + 4);
    exp_done(0, 1'b0, 32'h0044_FFBB, t + 9);
    fork
      hold_req(0, 1'b1, 1);
      hold_req(0, 1'b0, 1);
      begin
        repeat (5) @(posedge clk);
        #1;
        check("u0_waitcount_at_fetch_grant", 32'(wait_count[0]), 32'd5);
      end
    join

    // Store leaves DmRdata untouched; the following load returns the stored word.
    start(t);
    dm_addr[0]  = 32'h100;
    dm_we[0]    = 1'b1;
    dm_wdata[0] = 32'hDEAD_BEEF;
    exp_iss(0, 1'b1, 32'h100, 32'hDEAD_BEEF, t + 1);
    exp_done(0, 1'b1, 32'h0080_FF7F, t + 4);
    hold_req(0, 1'b1, 1);

    start(t);
    dm_we[0] = 1'b0;
    exp_iss(0, 1'b0, 32'h100, 32'd0, t + 1);
    exp_done(0, 1'b1, 32'hDEAD_BEEF, t + 4);
    hold_req(0, 1'b1, 1);

    start(t);
    if_addr[0] = 32'h40;
    exp_iss(0, 1'b0, 32'h40, 32'd0, t + 1);
    exp_done(0, 1'b0, 32'h8C22_0004, t + 4);
    hold_req(0, 1'b0, 1);

    // Continuous conflict: data, fetch, data, fetch.
    start(t);
    if_addr[0] = 32'h48;
    dm_addr[0] = 32'h104;
    for (int j = 0; j < 4; j++) begin
      exp_iss(0, 1'b0, (j % 2 == 0) ? 32'h104 : 32'h48, 32'd0, t + 1 + 5 * j);
      exp_done(0, (j % 2 == 0), (j % 2 == 0) ? 32'h0104_FEFB : 32'h0048_FFB7, t + 4 + 5 * j);
    end
    fork
      hold_req(0, 1'b1, 2);
      hold_req(0, 1'b0, 2);
    join

    // Reset during WAIT abandons the access.
    start(t);
    if_addr[0] = 32'h40;
    dm_addr[0] = 32'h80;
    exp_iss(0, 1'b0, 32'h80, 32'd0, t + 1);
    if_req[0] = 1'b1;
    dm_req[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("u0_waitcount_before_reset", 32'(wait_count[0]), 32'd22);
    rst       = 1'b1;
    if_req[0] = 1'b0;
    dm_req[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("u0_midrst_busy", 32'(busy[0]), 32'd0);
    check("u0_midrst_memen", 32'(mem_en[0]), 32'd0);
    check("u0_midrst_done", 32'(if_done[0] | dm_done[0]), 32'd0);
    check("u0_midrst_waitcount", 32'(wait_count[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    t = cyc;
    exp_iss(0, 1'b0, 32'h40, 32'd0, t + 1);
    exp_done(0, 1'b0, 32'h8C22_0004, t + 4);
    hold_req(0, 1'b0, 1);

    // Latency extremes.
    start(t);
    if_addr[1] = 32'h44;
    dm_addr[2] = 32'h80;
    dm_we[2]   = 1'b0;
    exp_iss(1, 1'b0, 32'h44, 32'd0, t + 1);
    exp_done(1, 1'b0, 32'h0044_FFBB, t + 3);
    exp_iss(2, 1'b0, 32'h80, 32'd0, t + 1);
    exp_done(2, 1'b1, 32'h0080_FF7F, t + 17);
    fork
      hold_req(1, 1'b0, 1);
      hold_req(2, 1'b1, 1);
    join

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d_done_q_empty", i), 32'(done_q[i].size()), 32'd0);
      check($sformatf("u%0d_iss_q_empty", i), 32'(iss_q[i].size()), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
